ladybird_axi_sram: RTL and testbench

Synthesizable AXI4-Lite responder backing store for the ladybird core. It sits on the slave end of `ladybird_axi_interface` opposite `ladybird_core`, and serves instruction and data accesses from an on-chip byte-strobed word array. A byte-wide load port lets a bench or boot loader fill memory before `start` without touching the AXI side. It replaces the behavioural simulation memory in synthesizable builds.

---
 rtl/ladybird_axi_pkg.sv | 26 ++
 rtl/ladybird_axi_interface.sv | 34 +++
 rtl/ladybird_sram_array.sv | 33 +++
 rtl/ladybird_axi_sram.sv | 238 +++++++++++++++++++++++
 tb/tb_ladybird_axi_sram.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_axi_pkg.sv
// Shared types and address decode for the ladybird AXI4-Lite SRAM responder.
package ladybird_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } axi_wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } axi_rd_state_e;

    // offset is already (addr - base) wrapped to the address width
    function automatic logic addr_in_range(input logic [63:0] offset,
                                           input logic [63:0] depth_words);
        return offset < (depth_words << 2);
    endfunction

endpackage

// File: rtl/ladybird_axi_interface.sv
// AXI4-Lite channel bundle between ladybird_core (master) and its memory (slave).
interface ladybird_axi_interface #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/ladybird_sram_array.sv
// Single-port DEPTH x 32 word array with byte enables and registered read data.
module ladybird_sram_array #(
    parameter int DEPTH = 16384,
    parameter int IDX_W = 14
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-enabled write and read-on-demand; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ladybird_axi_sram.sv
// AXI4-Lite slave backing store for ladybird_core with a byte-wide backdoor loader.
module ladybird_axi_sram
    import ladybird_axi_pkg::*;
#(
    parameter int                    AXI_DATA_W = 32,
    parameter int                    AXI_ADDR_W = 32,
    parameter int                    DEPTH      = 16384,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = {AXI_ADDR_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  nrst,
    ladybird_axi_interface.slave  axi,
    input  logic                  ld_valid,
    input  logic [AXI_ADDR_W-1:0] ld_addr,
    input  logic [7:0]            ld_data
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (AXI_DATA_W != 32) begin : g_bad_data_width
        $error("ladybird_axi_sram supports only AXI_DATA_W = 32");
    end

    axi_wr_state_e         wr_state_q, wr_state_d;
    axi_rd_state_e         rd_state_q, rd_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [AXI_ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    axi_resp_t             bresp_q, bresp_d;
    logic                  ar_en_q, ar_en_d;
    logic                  rvalid_q, rvalid_d;
    axi_resp_t             rresp_q, rresp_d;
    logic                  rd_ok_q, rd_ok_d;

    logic [AXI_ADDR_W-1:0] ld_off_s, aw_off_s, ar_off_s;
    logic                  ld_in_range_s, aw_in_range_s, ar_in_range_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s, arready_s;
    logic                  mem_we_s, mem_re_s;
    logic [3:0]            mem_be_s;
    logic [IDX_W-1:0]      mem_addr_s;
    logic [31:0]           mem_wdata_s, mem_rdata_s;

    assign ld_off_s      = ld_addr - BASE_ADDR;
    assign aw_off_s      = awaddr_q - BASE_ADDR;
    assign ar_off_s      = axi.araddr - BASE_ADDR;
    assign ld_in_range_s = addr_in_range(64'(ld_off_s), 64'(DEPTH));
    assign aw_in_range_s = addr_in_range(64'(aw_off_s), 64'(DEPTH));
    assign ar_in_range_s = addr_in_range(64'(ar_off_s), 64'(DEPTH));

    assign aw_hs_s   = axi.awvalid && awready_q;
    assign w_hs_s    = axi.wvalid && wready_q;
    // The array port is owned by the loader or a pending commit in those cycles
    assign arready_s = ar_en_q && (wr_state_q != W_COMMIT) && !ld_valid;
    assign ar_hs_s   = axi.arvalid && arready_s;

    // Write FSM next state: collect AW and W in any order, commit, then respond
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = axi.awaddr;
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_hs_s) begin
                    w_held_d = 1'b1;
                    wdata_d  = axi.wdata;
                    wstrb_d  = axi.wstrb;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = W_COMMIT;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_COMMIT: begin
                if (ld_valid) begin
                    wr_state_d = W_COMMIT;
                end else begin
                    if (aw_in_range_s) begin
                        bresp_d = OKAY;
                    end else begin
                        bresp_d = SLVERR;
                    end
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                wr_state_d = W_IDLE;
            end
        endcase
        awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
        bvalid_d  = (wr_state_d == W_RESP);
    end

    // Read FSM next state: one outstanding read, response held until rready
    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        rd_ok_d    = rd_ok_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rd_ok_d    = ar_in_range_s;
                    if (ar_in_range_s) begin
                        rresp_d = OKAY;
                    end else begin
                        rresp_d = SLVERR;
                    end
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (axi.rready) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
        ar_en_d  = (rd_state_d == R_IDLE);
        rvalid_d = (rd_state_d == R_DATA);
    end

    // Array port arbitration: loader, then write commit, then read
    always_comb begin
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_be_s    = 4'b0000;
        mem_addr_s  = {IDX_W{1'b0}};
        mem_wdata_s = 32'h0000_0000;
        if (ld_valid) begin
            mem_we_s    = ld_in_range_s;
            mem_be_s    = 4'b0001 << ld_addr[1:0];
            mem_addr_s  = ld_off_s[IDX_W+1:2];
            mem_wdata_s = {4{ld_data}};
        end else if (nrst && (wr_state_q == W_COMMIT)) begin
            mem_we_s    = aw_in_range_s;
            mem_be_s    = wstrb_q;
            mem_addr_s  = aw_off_s[IDX_W+1:2];
            mem_wdata_s = wdata_q;
        end else begin
            mem_re_s    = nrst && ar_hs_s && ar_in_range_s;
            mem_addr_s  = ar_off_s[IDX_W+1:2];
        end
    end

    // State and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= {AXI_ADDR_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            ar_en_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rd_ok_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ar_en_q    <= ar_en_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    ladybird_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .be    (mem_be_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_s;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rd_ok_q ? mem_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_ladybird_axi_sram.sv
// Directed bench for ladybird_axi_sram: vector table plus hand-written corner sequences.
module tb_ladybird_axi_sram;
    import ladybird_axi_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    ladybird_axi_interface #(.DATA_W(32), .ADDR_W(32)) axi_if ();

    ladybird_axi_sram #(
        .AXI_DATA_W (32),
        .AXI_ADDR_W (32),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .axi      (axi_if),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_awready"}, 32'(axi_if.awready), 32'h0);
        chk({tag, "_wready"},  32'(axi_if.wready),  32'h0);
        chk({tag, "_arready"}, 32'(axi_if.arready), 32'h0);
        chk({tag, "_bvalid"},  32'(axi_if.bvalid),  32'h0);
        chk({tag, "_rvalid"},  32'(axi_if.rvalid),  32'h0);
        chk({tag, "_bresp"},   32'(axi_if.bresp),   32'h0);
        chk({tag, "_rresp"},   32'(axi_if.rresp),   32'h0);
        chk({tag, "_rdata"},   axi_if.rdata,        32'h0);
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Starts at the first negedge after the last AW/W handshake; lat = cycles to bvalid
    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (axi_if.bvalid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        resp = axi_if.bresp;
        if (lat != 0) begin
            axi_if.bready = 1'b1;
            @(negedge clk);
            axi_if.bready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit go_aw, go_w;
        axi_if.awvalid = 1'b1;
        axi_if.awaddr  = a;
        axi_if.wvalid  = 1'b1;
        axi_if.wdata   = d;
        axi_if.wstrb   = s;
        for (int i = 0; i < 10; i++) begin
            #1;
            go_aw = axi_if.awvalid && axi_if.awready;
            go_w  = axi_if.wvalid && axi_if.wready;
            @(negedge clk);
            if (go_aw) begin
                axi_if.awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (go_w) begin
                axi_if.wvalid = 1'b0;
                w_done = 1'b1;
            end
            if (aw_done && w_done) break;
        end
        axi_if.awvalid = 1'b0;
        axi_if.wvalid  = 1'b0;
        chk("wr_handshake", {30'h0, aw_done, w_done}, 32'h3);
        wait_b(resp, lat);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit got = 1'b0;
        axi_if.arvalid = 1'b1;
        axi_if.araddr  = a;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (axi_if.arready) begin
                got = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        axi_if.arvalid = 1'b0;
        chk("ar_handshake", 32'(got), 32'h1);
        chk("rvalid_next_cycle", 32'(axi_if.rvalid), 32'h1);
        d    = axi_if.rdata;
        resp = axi_if.rresp;
        axi_if.rready = 1'b1;
        @(negedge clk);
        axi_if.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          lat;
        bit          seen_b;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0013, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AB00,  4'h2, 32'h0,         2'b00};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_ABEF, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF,  4'hF, 32'h0,         2'b10};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0013, 2'b00};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,          4'h0, 32'h0000_0000, 2'b10};
        vecs[7]  = '{1'b1, 32'h0000_003C, 32'h1234_5678,  4'hF, 32'h0,         2'b00};
        vecs[8]  = '{1'b0, 32'h0000_003F, 32'h0,          4'h0, 32'h1234_5678, 2'b00};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'h0000_0000,  4'h0, 32'h0,         2'b00};
        vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,          4'h0, 32'h1234_5678, 2'b00};
        vecs[11] = '{1'b1, 32'h0000_0044, 32'h0000_0000,  4'h0, 32'h0,         2'b10};
        vecs[12] = '{1'b1, 32'h0000_0020, 32'h1122_3344,  4'hF, 32'h0,         2'b00};
        vecs[13] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD,  4'h9, 32'h0,         2'b00};
        vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'hAA22_33DD, 2'b00};
        vecs[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          4'h0, 32'h0000_0000, 2'b10};

        nrst = 1'b0;
        ld_valid = 1'b0;
        ld_addr = 32'h0;
        ld_data = 8'h00;
        axi_if.awvalid = 1'b0;
        axi_if.awaddr  = 32'h0;
        axi_if.wvalid  = 1'b0;
        axi_if.wdata   = 32'h0;
        axi_if.wstrb   = 4'h0;
        axi_if.bready  = 1'b0;
        axi_if.arvalid = 1'b0;
        axi_if.araddr  = 32'h0;
        axi_if.rready  = 1'b0;

        repeat (2) @(negedge clk);
        chk_all_low("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_awready", 32'(axi_if.awready), 32'h1);
        chk("idle_wready",  32'(axi_if.wready),  32'h1);
        chk("idle_arready", 32'(axi_if.arready), 32'h1);

        load_byte(32'h0, 8'h13);
        load_byte(32'h1, 8'h00);
        load_byte(32'h2, 8'h00);
        load_byte(32'h3, 8'h00);

        // W two cycles ahead of AW
        axi_if.wvalid = 1'b1;
        axi_if.wdata  = 32'hDEAD_BEEF;
        axi_if.wstrb  = 4'hF;
        #1;
        chk("wfirst_wready", 32'(axi_if.wready), 32'h1);
        @(negedge clk);
        axi_if.wvalid = 1'b0;
        chk("wfirst_wready_held", 32'(axi_if.wready), 32'h0);
        chk("wfirst_awready", 32'(axi_if.awready), 32'h1);
        @(negedge clk);
        axi_if.awvalid = 1'b1;
        axi_if.awaddr  = 32'h10;
        @(negedge clk);
        axi_if.awvalid = 1'b0;
        wait_b(rsp, lat);
        chk("wfirst_b_latency", 32'(lat), 32'd2);
        chk("wfirst_bresp", 32'(rsp), 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp, lat);
                chk($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_b_latency", i), 32'(lat), 32'd2);
            end else begin
                do_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
            end
        end

        // Read backpressure: rdata stable, no new AR accepted
        axi_if.arvalid = 1'b1;
        axi_if.araddr  = 32'h10;
        #1;
        chk("bp_arready", 32'(axi_if.arready), 32'h1);
        @(negedge clk);
        axi_if.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rvalid", i), 32'(axi_if.rvalid), 32'h1);
            chk($sformatf("bp%0d_rdata", i), axi_if.rdata, 32'hDEAD_ABEF);
            chk($sformatf("bp%0d_arready", i), 32'(axi_if.arready), 32'h0);
            @(negedge clk);
        end
        axi_if.rready = 1'b1;
        @(negedge clk);
        axi_if.rready = 1'b0;
        chk("bp_rvalid_drop", 32'(axi_if.rvalid), 32'h0);

        // Loader collides with W_COMMIT: commit slips one cycle, both land
        axi_if.awvalid = 1'b1;
        axi_if.awaddr  = 32'h14;
        axi_if.wvalid  = 1'b1;
        axi_if.wdata   = 32'hCAFE_F00D;
        axi_if.wstrb   = 4'hF;
        @(negedge clk);
        axi_if.awvalid = 1'b0;
        axi_if.wvalid  = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h3;
        ld_data  = 8'h5A;
        #1;
        chk("coll_arready", 32'(axi_if.arready), 32'h0);
        @(negedge clk);
        ld_valid = 1'b0;
        chk("coll_bvalid_slip", 32'(axi_if.bvalid), 32'h0);
        wait_b(rsp, lat);
        chk("coll_b_latency", 32'(lat), 32'd2);
        chk("coll_bresp", 32'(rsp), 32'h0);
        do_read(32'h14, rd, rsp);
        chk("coll_commit_data", rd, 32'hCAFE_F00D);
        do_read(32'h0, rd, rsp);
        chk("coll_load_data", rd, 32'h5A00_0013);

        // Load in cycle N visible to a read accepted in N+1; out-of-range load dropped
        ld_valid = 1'b1;
        ld_addr  = 32'h2;
        ld_data  = 8'h44;
        #1;
        chk("load_arready", 32'(axi_if.arready), 32'h0);
        @(negedge clk);
        ld_valid = 1'b0;
        do_read(32'h0, rd, rsp);
        chk("load_then_read", rd, 32'h5A44_0013);
        load_byte(32'h40, 8'hEE);
        do_read(32'h0, rd, rsp);
        chk("load_oor_dropped", rd, 32'h5A44_0013);

        // Reset between AW and W discards the held AW
        axi_if.awvalid = 1'b1;
        axi_if.awaddr  = 32'h24;
        @(negedge clk);
        axi_if.awvalid = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        chk_all_low("midreset");
        nrst = 1'b1;
        @(negedge clk);
        axi_if.wvalid = 1'b1;
        axi_if.wdata  = 32'h0BAD_F00D;
        axi_if.wstrb  = 4'hF;
        #1;
        chk("midreset_wready", 32'(axi_if.wready), 32'h1);
        @(negedge clk);
        axi_if.wvalid = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_b = seen_b | axi_if.bvalid;
            @(negedge clk);
        end
        chk("midreset_no_bvalid", 32'(seen_b), 32'h0);
        chk("midreset_awready", 32'(axi_if.awready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
